// File: rtl/alu_seq_if.sv
`default_nettype none
// ============================================================================
//  Module      : alu_seq_if
//  Description : Request/response bundle for alu_seq. The master drives
//                requests and accepts results; the slave (the ALU) accepts
//                requests and presents registered results.
//  Revision    : 1.0 - initial release
// ============================================================================
interface alu_seq_if #(
    parameter int XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [XLEN-1:0] srcA;
    logic [XLEN-1:0] srcB;
    logic [9:0]      ALUControl;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] ALUResult;
    logic            Zero;
    logic            illegal;

    modport master (
        output in_valid, srcA, srcB, ALUControl, out_ready,
        input  in_ready, out_valid, ALUResult, Zero, illegal
    );

    modport slave (
        input  in_valid, srcA, srcB, ALUControl, out_ready,
        output in_ready, out_valid, ALUResult, Zero, illegal
    );
endinterface
`default_nettype wire

// File: rtl/alu_seq.sv
`default_nettype none
// ============================================================================
//  Module      : alu_seq
//  Description : Handshaked RV-style ALU with registered outputs. Single-cycle
//                integer/branch ops; optional iterative multiply/divide
//                (one bit per cycle) enabled by macro ALU_SEQ_MULDIV_EN.
//                Without the macro, M opcodes report illegal.
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_seq #(
    parameter int XLEN = 32
) (
    input  wire logic  clk,
    input  wire logic  resetn,
    alu_seq_if.slave   bus
);
    localparam int SW = $clog2(XLEN);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_BUSY = 2'd1;
    localparam logic [1:0] c_DONE = 2'd2;

    localparam logic [9:0] c_OP_ADD  = 10'h000;
    localparam logic [9:0] c_OP_SUB  = 10'h100;
    localparam logic [9:0] c_OP_SLL  = 10'h001;
    localparam logic [9:0] c_OP_SLT  = 10'h002;
    localparam logic [9:0] c_OP_SLTU = 10'h003;
    localparam logic [9:0] c_OP_XOR  = 10'h004;
    localparam logic [9:0] c_OP_SRL  = 10'h005;
    localparam logic [9:0] c_OP_SRA  = 10'h105;
    localparam logic [9:0] c_OP_OR   = 10'h006;
    localparam logic [9:0] c_OP_AND  = 10'h007;
    localparam logic [9:0] c_OP_BEQ  = 10'h008;
    localparam logic [9:0] c_OP_BNE  = 10'h009;
    localparam logic [9:0] c_OP_BLT  = 10'h00A;
    localparam logic [9:0] c_OP_BGE  = 10'h00B;
    localparam logic [9:0] c_OP_BLTU = 10'h00C;
    localparam logic [9:0] c_OP_BGEU = 10'h00D;
    localparam logic [9:0] c_OP_LUI  = 10'h00E;

    logic [1:0]      r_state;
    logic [XLEN-1:0] r_result;
    logic            r_zero;
    logic            r_illegal;

    logic [XLEN-1:0] w_res;
    logic            w_zero;
    logic            w_ill;
    logic            w_is_m;
    logic            w_accept;
    logic [SW-1:0]   w_sh;
    logic            w_lt;
    logic            w_ltu;
    logic [XLEN-1:0] w_diff;

    assign w_accept      = (r_state == c_IDLE) && bus.in_valid;
    assign bus.in_ready  = (r_state == c_IDLE);
    assign bus.out_valid = (r_state == c_DONE);
    assign bus.ALUResult = r_result;
    assign bus.Zero      = r_zero;
    assign bus.illegal   = r_illegal;

    // Single-cycle result computed straight from the request being accepted
    always_comb begin
        w_sh   = bus.srcB[SW-1:0];
        w_lt   = $signed(bus.srcA) < $signed(bus.srcB);
        w_ltu  = bus.srcA < bus.srcB;
        w_diff = bus.srcA - bus.srcB;
        w_res  = '0;
        w_zero = 1'b0;
        w_ill  = 1'b0;
        case (bus.ALUControl)
            c_OP_ADD:  w_res = bus.srcA + bus.srcB;
            c_OP_SUB:  w_res = w_diff;
            c_OP_SLL:  w_res = bus.srcA << w_sh;
            c_OP_SLT:  w_res = {{(XLEN-1){1'b0}}, w_lt};
            c_OP_SLTU: w_res = {{(XLEN-1){1'b0}}, w_ltu};
            c_OP_XOR:  w_res = bus.srcA ^ bus.srcB;
            c_OP_SRL:  w_res = bus.srcA >> w_sh;
            c_OP_SRA:  w_res = $signed(bus.srcA) >>> w_sh;
            c_OP_OR:   w_res = bus.srcA | bus.srcB;
            c_OP_AND:  w_res = bus.srcA & bus.srcB;
            c_OP_BEQ:  begin w_res = w_diff; w_zero = (bus.srcA == bus.srcB); end
            c_OP_BNE:  begin w_res = w_diff; w_zero = (bus.srcA != bus.srcB); end
            c_OP_BLT:  begin w_res = w_diff; w_zero = w_lt;  end
            c_OP_BGE:  begin w_res = w_diff; w_zero = !w_lt; end
            c_OP_BLTU: begin w_res = w_diff; w_zero = w_ltu; end
            c_OP_BGEU: begin w_res = w_diff; w_zero = !w_ltu; end
            c_OP_LUI:  w_res = bus.srcB;
            default:   w_ill = 1'b1;
        endcase
    end

`ifdef ALU_SEQ_MULDIV_EN
    localparam logic [SW-1:0] c_LAST = SW'(XLEN - 1);

    // Multiply and divide share one {hi, lo} shift pair and operate on
    // magnitudes; signs are reapplied in the final cycle.
    logic [SW-1:0]     r_cnt;
    logic [XLEN-1:0]   r_hi;
    logic [XLEN-1:0]   r_lo;
    logic [XLEN-1:0]   r_mc;
    logic [2:0]        r_mop;
    logic              r_neg;
    logic              r_negr;
    logic              r_bzero;
    logic [XLEN-1:0]   r_a;

    logic              w_a_sgn;
    logic              w_b_sgn;
    logic [XLEN-1:0]   w_amag;
    logic [XLEN-1:0]   w_bmag;
    logic [XLEN:0]     w_sum;
    logic [XLEN:0]     w_shift;
    logic [XLEN:0]     w_dsub;
    logic [XLEN-1:0]   w_hi_n;
    logic [XLEN-1:0]   w_lo_n;
    logic [2*XLEN-1:0] w_prod;
    logic [2*XLEN-1:0] w_prod_s;
    logic [XLEN-1:0]   w_m_res;

    assign w_is_m = (bus.ALUControl[9:3] == 7'b1000000);

    // Operand sign/magnitude split at acceptance
    always_comb begin
        w_a_sgn = 1'b0;
        w_b_sgn = 1'b0;
        case (bus.ALUControl[2:0])
            3'd1, 3'd4, 3'd6: begin
                w_a_sgn = bus.srcA[XLEN-1];
                w_b_sgn = bus.srcB[XLEN-1];
            end
            3'd2:    w_a_sgn = bus.srcA[XLEN-1];
            default: ;
        endcase
        w_amag = w_a_sgn ? (~bus.srcA + 1'b1) : bus.srcA;
        w_bmag = w_b_sgn ? (~bus.srcB + 1'b1) : bus.srcB;
    end

    // One shift-add or restoring-subtract step, plus final sign fix-up
    always_comb begin
        w_sum   = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_mc} : {(XLEN+1){1'b0}});
        w_shift = {r_hi, r_lo[XLEN-1]};
        w_dsub  = w_shift - {1'b0, r_mc};
        if (r_mop[2]) begin
            if (!w_dsub[XLEN]) begin
                w_hi_n = w_dsub[XLEN-1:0];
                w_lo_n = {r_lo[XLEN-2:0], 1'b1};
            end else begin
                w_hi_n = w_shift[XLEN-1:0];
                w_lo_n = {r_lo[XLEN-2:0], 1'b0};
            end
        end else begin
            w_hi_n = w_sum[XLEN:1];
            w_lo_n = {w_sum[0], r_lo[XLEN-1:1]};
        end
        w_prod   = {w_hi_n, w_lo_n};
        w_prod_s = r_neg ? (~w_prod + 1'b1) : w_prod;
        case (r_mop)
            3'd0:       w_m_res = w_prod_s[XLEN-1:0];
            3'd1, 3'd2,
            3'd3:       w_m_res = w_prod_s[2*XLEN-1:XLEN];
            3'd4, 3'd5: w_m_res = r_bzero ? {XLEN{1'b1}}
                                 : (r_neg ? (~w_lo_n + 1'b1) : w_lo_n);
            default:    w_m_res = r_bzero ? r_a
                                 : (r_negr ? (~w_hi_n + 1'b1) : w_hi_n);
        endcase
    end

    // Iterative datapath: load at acceptance, step once per BUSY cycle
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_cnt   <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
            r_mc    <= '0;
            r_mop   <= '0;
            r_neg   <= 1'b0;
            r_negr  <= 1'b0;
            r_bzero <= 1'b0;
            r_a     <= '0;
        end else if (w_accept && w_is_m) begin
            r_cnt   <= '0;
            r_hi    <= '0;
            r_lo    <= w_amag;
            r_mc    <= w_bmag;
            r_mop   <= bus.ALUControl[2:0];
            r_neg   <= w_a_sgn ^ w_b_sgn;
            r_negr  <= w_a_sgn;
            r_bzero <= (bus.srcB == '0);
            r_a     <= bus.srcA;
        end else if (r_state == c_BUSY) begin
            r_cnt <= r_cnt + SW'(1);
            r_hi  <= w_hi_n;
            r_lo  <= w_lo_n;
        end
    end
`else
    assign w_is_m = 1'b0;
`endif

    // Control FSM and registered result
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state   <= c_IDLE;
            r_result  <= '0;
            r_zero    <= 1'b0;
            r_illegal <= 1'b0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (w_accept) begin
                        if (w_is_m) begin
                            r_state <= c_BUSY;
                        end else begin
                            r_state   <= c_DONE;
                            r_result  <= w_res;
                            r_zero    <= w_zero;
                            r_illegal <= w_ill;
                        end
                    end
                end
                c_BUSY: begin
`ifdef ALU_SEQ_MULDIV_EN
                    if (r_cnt == c_LAST) begin
                        r_state   <= c_DONE;
                        r_result  <= w_m_res;
                        r_zero    <= 1'b0;
                        r_illegal <= 1'b0;
                    end
`else
                    r_state <= c_IDLE;
`endif
                end
                c_DONE: begin
                    if (bus.out_ready) r_state <= c_IDLE;
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_alu_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_seq
//  Description : Self-checking bench for alu_seq (XLEN=32) with a behavioural
//                reference model; follows ALU_SEQ_MULDIV_EN like the design.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_seq;
    localparam int XLEN = 32;

    logic clk = 1'b0;
    logic resetn;
    always #5 clk = ~clk;

    alu_seq_if #(.XLEN(XLEN)) bus ();
    alu_seq #(.XLEN(XLEN)) dut (.clk(clk), .resetn(resetn), .bus(bus));

    int checks   = 0;
    int failures = 0;

    logic [9:0] c_ops [26] = '{10'h000, 10'h100, 10'h001, 10'h002, 10'h003,
                               10'h004, 10'h005, 10'h105, 10'h006, 10'h007,
                               10'h008, 10'h009, 10'h00A, 10'h00B, 10'h00C,
                               10'h00D, 10'h00E, 10'h200, 10'h201, 10'h202,
                               10'h203, 10'h204, 10'h205, 10'h206, 10'h207,
                               10'h3FF};

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Reference behaviour from the operation definitions
    function automatic void model(input logic [9:0] op, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] r, output logic z, output logic il,
                                  output int lat);
        int          sa;
        int          sb;
        longint      ps;
        logic [63:0] ub;
        logic [63:0] pu;
        sa  = a;
        sb  = b;
        r   = 32'h0;
        z   = 1'b0;
        il  = 1'b0;
        lat = 1;
        case (op)
            10'h000: r = a + b;
            10'h100: r = a - b;
            10'h001: r = a << b[4:0];
            10'h002: r = (sa < sb) ? 32'd1 : 32'd0;
            10'h003: r = (a < b) ? 32'd1 : 32'd0;
            10'h004: r = a ^ b;
            10'h005: r = a >> b[4:0];
            10'h105: r = sa >>> b[4:0];
            10'h006: r = a | b;
            10'h007: r = a & b;
            10'h008: begin r = a - b; z = (a == b); end
            10'h009: begin r = a - b; z = (a != b); end
            10'h00A: begin r = a - b; z = (sa < sb); end
            10'h00B: begin r = a - b; z = (sa >= sb); end
            10'h00C: begin r = a - b; z = (a < b); end
            10'h00D: begin r = a - b; z = (a >= b); end
            10'h00E: r = b;
`ifdef ALU_SEQ_MULDIV_EN
            10'h200: begin lat = 33; pu = 64'(a) * 64'(b); r = pu[31:0]; end
            10'h201: begin lat = 33; ps = longint'(sa) * longint'(sb); r = ps[63:32]; end
            10'h202: begin lat = 33; ub = 64'(b); ps = longint'(sa) * longint'(ub); r = ps[63:32]; end
            10'h203: begin lat = 33; pu = 64'(a) * 64'(b); r = pu[63:32]; end
            10'h204: begin
                lat = 33;
                if (b == 0) r = 32'hFFFF_FFFF;
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = a;
                else r = sa / sb;
            end
            10'h205: begin lat = 33; r = (b == 0) ? 32'hFFFF_FFFF : a / b; end
            10'h206: begin
                lat = 33;
                if (b == 0) r = a;
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = 0;
                else r = sa % sb;
            end
            10'h207: begin lat = 33; r = (b == 0) ? a : a % b; end
`endif
            default: il = 1'b1;
        endcase
    endfunction

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 6))
            0:       return 32'h0;
            1:       return 32'h1;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h8000_0000;
            4:       return 32'($urandom_range(0, 40));
            default: return $urandom;
        endcase
    endfunction

    // Issue one request, check latency/result, optionally stall in DONE
    task automatic do_op(input logic [9:0] op, input logic [31:0] a, input logic [31:0] b,
                         input bit hold, input int stall, input string tag);
        logic [31:0] er;
        logic        ez;
        logic        eil;
        int          elat;
        int          cyc;
        model(op, a, b, er, ez, eil, elat);
        @(negedge clk);
        bus.srcA       = a;
        bus.srcB       = b;
        bus.ALUControl = op;
        bus.in_valid   = 1'b1;
        bus.out_ready  = (stall == 0);
        check({tag, " in_ready_before"}, bus.in_ready, 1);
        @(posedge clk);
        #1;
        bus.in_valid   = hold;
        bus.srcA       = $urandom;
        bus.srcB       = $urandom;
        bus.ALUControl = 10'($urandom);
        cyc = 1;
        while (!bus.out_valid && cyc < 100) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        bus.in_valid = 1'b0;
        check({tag, " latency"}, 64'(cyc), 64'(elat));
        check({tag, " result"}, bus.ALUResult, er);
        check({tag, " zero"}, bus.Zero, ez);
        check({tag, " illegal"}, bus.illegal, eil);
        for (int i = 0; i < stall; i++) begin
            @(posedge clk);
            #1;
            check({tag, " stall_valid"}, bus.out_valid, 1);
            check({tag, " stall_result"}, bus.ALUResult, er);
            check({tag, " stall_in_ready"}, bus.in_ready, 0);
        end
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        check({tag, " valid_drop"}, bus.out_valid, 0);
        check({tag, " in_ready_after"}, bus.in_ready, 1);
    endtask

    initial begin
        logic [9:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        bit          seen;

        resetn         = 1'b0;
        bus.in_valid   = 1'b0;
        bus.out_ready  = 1'b1;
        bus.srcA       = '0;
        bus.srcB       = '0;
        bus.ALUControl = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset out_valid", bus.out_valid, 0);
        check("reset result", bus.ALUResult, 0);
        check("reset zero", bus.Zero, 0);
        check("reset illegal", bus.illegal, 0);
        @(negedge clk);
        resetn = 1'b1;
        @(posedge clk);
        #1;
        check("post-reset in_ready", bus.in_ready, 1);

        do_op(10'h000, 32'd7, 32'd5, 1'b0, 0, "add7+5");
        do_op(10'h00C, 32'd1, 32'hFFFF_FFFF, 1'b0, 0, "bltu");
        do_op(10'h00A, 32'd1, 32'hFFFF_FFFF, 1'b0, 0, "blt");
        do_op(10'h00D, 32'd1, 32'hFFFF_FFFF, 1'b0, 0, "bgeu");
        do_op(10'h008, 32'h1234, 32'h1234, 1'b0, 0, "beq");
        do_op(10'h105, 32'h8000_0010, 32'hFFFF_FFE4, 1'b0, 0, "sra");
        do_op(10'h001, 32'h0000_0003, 32'h0000_0025, 1'b0, 0, "sll");
        do_op(10'h00E, 32'h1111_1111, 32'hABCD_E000, 1'b0, 0, "lui");
        do_op(10'h201, 32'h8000_0000, 32'h8000_0000, 1'b1, 0, "mulh");
        do_op(10'h204, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 0, "div_ovf");
        do_op(10'h206, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 0, "rem_ovf");
        do_op(10'h205, 32'd5, 32'd0, 1'b0, 0, "divu0");
        do_op(10'h207, 32'd5, 32'd0, 1'b0, 0, "remu0");
        do_op(10'h204, 32'hFFFF_FFF9, 32'd0, 1'b0, 0, "div0");
        do_op(10'h206, 32'hFFFF_FFF9, 32'd2, 1'b0, 0, "rem_neg");
        do_op(10'h202, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 0, "mulhsu");
        do_op(10'h200, 32'd3, 32'd4, 1'b0, 0, "mul3x4");
        do_op(10'h3FF, 32'd3, 32'd4, 1'b0, 0, "op3ff");
        do_op(10'h000, 32'hDEAD_0000, 32'h0000_BEEF, 1'b0, 10, "add_stall");

        // Reset while an operation is in flight discards it
        @(negedge clk);
        bus.srcA       = 32'd3;
        bus.srcB       = 32'd4;
        bus.ALUControl = 10'h200;
        bus.in_valid   = 1'b1;
        bus.out_ready  = 1'b0;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        resetn = 1'b0;
        #1;
        check("midreset out_valid", bus.out_valid, 0);
        check("midreset result", bus.ALUResult, 0);
        check("midreset illegal", bus.illegal, 0);
        check("midreset in_ready", bus.in_ready, 1);
        @(negedge clk);
        resetn = 1'b1;
        seen   = 1'b0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (bus.out_valid) seen = 1'b1;
        end
        check("midreset no_result", seen, 0);
        bus.out_ready = 1'b1;

        for (int n = 0; n < 60; n++) begin
            if ($urandom_range(0, 9) == 0) op = 10'($urandom);
            else op = c_ops[$urandom_range(0, 25)];
            a = pick_operand();
            b = pick_operand();
            do_op(op, a, b, 1'($urandom_range(0, 1)), ($urandom_range(0, 4) == 0) ? 2 : 0, "rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 The block SHALL have one parameter: XLEN, default 32, the operand/result width; legal values are 8, 16, 32 and 64.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 resetn  input  1  reset, asynchronous assert, active-low.
REQ-004 in_valid  input  1  operation request.
REQ-005 in_ready  output  1  block can accept a request.
REQ-006 srcA  input  XLEN  first operand.
REQ-007 srcB  input  XLEN  second operand.
REQ-008 ALUControl  input  10  operation select.
REQ-009 out_valid  output  1  ALUResult and Zero are valid.
REQ-010 out_ready  input  1  consumer accepts the result.
REQ-011 ALUResult  output  XLEN  registered result.
REQ-012 Zero  output  1  registered branch-taken condition.
REQ-013 illegal  output  1  registered unsupported-opcode flag.

Function
REQ-014 Encodings SHALL be: ADD 0x000, SUB 0x100, SLL 0x001, SLT 0x002, SLTU 0x003, XOR 0x004, SRL 0x005, SRA 0x105, OR 0x006, AND 0x007, BEQ 0x008, BNE 0x009, BLT 0x00A, BGE 0x00B, BLTU 0x00C, BGEU 0x00D, LUI 0x00E, MUL 0x200, MULH 0x201, MULHSU 0x202, MULHU 0x203, DIV 0x204, DIVU 0x205, REM 0x206, REMU 0x207.
REQ-015 States SHALL be IDLE, BUSY and DONE; in_ready = (state == IDLE).
REQ-016 A request is accepted when in_valid && in_ready; srcA, srcB and ALUControl SHALL be captured at acceptance and later input changes SHALL have no effect.
REQ-017 Non-M opcodes: IDLE -> DONE on acceptance; out_valid SHALL rise on the next clock edge (latency 1).
REQ-018 M opcodes: IDLE -> BUSY; one bit per cycle iterative shift-add / restoring divide; BUSY -> DONE so that out_valid rises exactly XLEN+1 cycles after acceptance, operand-independent.
REQ-019 DONE SHALL hold ALUResult, Zero, illegal stable until out_valid && out_ready, then go to IDLE; the next acceptance is possible one cycle later.
REQ-020 Shift amounts SHALL use srcB[log2(XLEN)-1:0] only; SRA sign-fills.
REQ-021 Branch ops: ALUResult = srcA - srcB; Zero = 1 for BEQ equal, BNE unequal, BLT signed less, BGE signed greater-or-equal, BLTU unsigned less, BGEU unsigned greater-or-equal.
REQ-022 Non-branch ops SHALL drive Zero = 0; LUI SHALL return srcB.
REQ-023 MUL returns low XLEN bits; MULH/MULHSU/MULHU return high XLEN bits with signed x signed, signed x unsigned, unsigned x unsigned operands.
REQ-024 Divide by zero: DIV/DIVU quotient all-ones, REM/REMU remainder = srcA.
REQ-025 Signed overflow (srcA = most-negative, srcB = -1): DIV returns srcA, REM returns 0.
REQ-026 Unlisted encodings SHALL complete with latency 1, ALUResult = 0, Zero = 0, illegal = 1.
REQ-027 All outputs SHALL be registered; no output SHALL combinationally depend on srcA, srcB or ALUControl.

Reset
REQ-028 resetn low SHALL immediately force IDLE, out_valid = 0, ALUResult = 0, Zero = 0, illegal = 0, and clear iteration counter and partial products.
REQ-029 Reset during BUSY or DONE SHALL discard the operation; no out_valid SHALL follow for it.
REQ-030 After resetn rises, in_ready SHALL be 1 from the first clock edge.

Configuration
REQ-031 Macro ALU_SEQ_MULDIV_EN defined: M opcodes behave per REQ-018, REQ-023..025.
REQ-032 ALU_SEQ_MULDIV_EN undefined: no multiply/divide datapath is synthesised; M opcodes are treated as unlisted per REQ-026 (latency 1, illegal = 1).

Verification
REQ-033 XLEN=32, ADD 7+5, out_ready=1 -> out_valid one cycle after acceptance, ALUResult = 12, Zero = 0, then in_ready = 1 next cycle.
REQ-034 BLTU srcA=1, srcB=0xFFFFFFFF -> Zero = 1; BLT same operands -> Zero = 0; BGEU same -> Zero = 0.
REQ-035 MULH 0x80000000 x 0x80000000, macro defined -> out_valid exactly 33 cycles after acceptance, ALUResult = 0x40000000; in_valid held high during BUSY ignored.
REQ-036 DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; DIVU 5/0 -> 0xFFFFFFFF; REMU 5/0 -> 5.
REQ-037 out_ready held low 10 cycles in DONE -> ALUResult stable, in_ready = 0; resetn pulsed low mid-BUSY -> out_valid = 0 immediately, no result emerges.
REQ-038 Macro undefined, MUL 3x4 -> latency 1, ALUResult = 0, illegal = 1; opcode 0x3FF same response in both builds.
